// File: rtl/key_mode_ctrl.sv
// key_mode_ctrl: debounces two active-low keys and selects happy/sad/none display mode.
// Optional macro AUTO_TOGGLE_EN adds an idle auto-swap between HAPPY and SAD.
module key_mode_ctrl #(
    parameter int unsigned DEB_CYCLES  = 20000,
    parameter logic [23:0] AUTO_CYCLES = 24'd10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] key_raw,
    output logic [1:0] mode_out,
    output logic [1:0] press_pulse,
    output logic [1:0] key_db
);
    typedef enum logic [1:0] {NONE, HAPPY, SAD} state_t;

    localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);

    logic [1:0]  sync1, sync2, db_q, db_qq;
    logic [15:0] cnt [2];
    state_t      state, state_next;
    logic [1:0]  mode_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= 2'b11;
            sync2       <= 2'b11;
            db_q        <= 2'b11;
            db_qq       <= 2'b11;
            press_pulse <= 2'b00;
        end else begin
            sync1       <= key_raw;
            sync2       <= sync1;
            db_q        <= key_db;
            db_qq       <= db_q;
            press_pulse <= db_qq & ~db_q;
        end
    end

    // Counter runs only while the synchronized level disagrees with the accepted level
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                cnt[i]    <= '0;
                key_db[i] <= 1'b1;
            end else if (sync2[i] == key_db[i]) begin
                cnt[i] <= '0;
            end else if (cnt[i] == DEB_LAST) begin
                cnt[i]    <= '0;
                key_db[i] <= sync2[i];
            end else begin
                cnt[i] <= cnt[i] + 16'd1;
            end
        end
    end

`ifdef AUTO_TOGGLE_EN
    localparam logic [23:0] AUTO_LAST = AUTO_CYCLES - 24'd1;
    logic [23:0] auto_cnt;
    logic        swap;

    assign swap = (press_pulse == 2'b00) && (state != NONE) && (auto_cnt == AUTO_LAST);

    always_ff @(posedge clk) begin
        if (rst || press_pulse != 2'b00 || state == NONE || swap)
            auto_cnt <= '0;
        else
            auto_cnt <= auto_cnt + 24'd1;
    end
`else
    logic swap;
    logic unused_auto;
    assign swap        = 1'b0;
    assign unused_auto = ^AUTO_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= NONE;
            mode_out <= 2'b00;
        end else begin
            state    <= state_next;
            mode_out <= mode_next;
        end
    end

    // A single-key press wins over the auto swap; a simultaneous double press is ignored
    always_comb begin
        state_next = state;
        state_next = press_pulse == 2'b10 ? HAPPY :
                     press_pulse == 2'b01 ? SAD   :
                     swap ? (state == HAPPY ? SAD : HAPPY) : state;
        mode_next  = state_next == HAPPY ? 2'b10 :
                     state_next == SAD   ? 2'b01 : 2'b00;
    end
endmodule
